// File: rtl/button_monitor.sv
// button_monitor: synchronises a raw push-button, debounces it and emits one
// registered pulse per accepted press.
module button_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic keyEdge
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic REL = KEY_ACTIVE_LOW;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt, cnt_inc;
  logic sync_key, db_key, accept;
  assign sync_key = sync[SYNC_STAGES-1];
  assign cnt_inc = cnt + CW'(1);
  assign accept = (sync_key != db_key) && (cnt_inc == CW'(DEBOUNCE_CYCLES));
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync <= {SYNC_STAGES{REL}};
      db_key <= REL;
      cnt <= '0;
      keyEdge <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key};
      db_key <= accept ? sync_key : db_key;
      cnt <= (sync_key == db_key || accept) ? '0 : cnt_inc;
      keyEdge <= accept && (sync_key != REL);
    end
endmodule

// File: tb/tb_button_monitor.sv
// tb_button_monitor: three parameterisations of button_monitor checked against
// a window-based debounce model plus directed tables and corner sequences.
module tb_button_monitor;
  logic clock = 1'b0, reset = 1'b0;
  logic k0 = 1'b1, k1 = 1'b1, k2 = 1'b0;
  logic e0, e1, e2;
  int errors = 0, checks = 0, n = 0;
  bit h[3][4096];
  bit db[3];
  int pc[3], last[3];
  typedef struct {bit k; bit e;} vec_t;
  vec_t tv[12];

  always #5 clock = ~clock;

  button_monitor u0 (.clock(clock), .reset(reset), .key(k0), .keyEdge(e0));
  button_monitor #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1'b1))
    u1 (.clock(clock), .reset(reset), .key(k1), .keyEdge(e1));
  button_monitor #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .KEY_ACTIVE_LOW(1'b0))
    u2 (.clock(clock), .reset(reset), .key(k2), .keyEdge(e2));

  function automatic int ss(int i); return i == 2 ? 3 : 2; endfunction
  function automatic int dd(int i); return i == 1 ? 4 : 1; endfunction
  function automatic bit rel(int i); return i != 2; endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n, act, exp);
    end
  endtask

  // Accepted when the last DEBOUNCE_CYCLES synchronised samples all differ from db.
  function automatic bit win(int i);
    bit v;
    for (int j = n - ss(i) - dd(i) + 1; j <= n - ss(i); j++) begin
      v = (j < 1) ? rel(i) : h[i][j];
      if (v == db[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit a, input bit b, input bit c);
    bit exp;
    bit act[3];
    k0 = a; k1 = b; k2 = c;
    n++;
    h[0][n] = a; h[1][n] = b; h[2][n] = c;
    @(posedge clock); #1;
    act[0] = e0; act[1] = e1; act[2] = e2;
    for (int i = 0; i < 3; i++) begin
      exp = 1'b0;
      if (win(i)) begin
        exp = (db[i] == rel(i));
        db[i] = !db[i];
      end
      check($sformatf("model_u%0d", i), act[i], exp);
      if (act[i]) begin pc[i]++; last[i] = n; end
    end
    @(negedge clock);
  endtask

  task automatic do_reset(input bit a, input bit b, input bit c);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k0 = 1'($urandom); k1 = 1'($urandom); k2 = 1'($urandom);
      @(posedge clock); #1;
      check("rst_u0", e0, 0); check("rst_u1", e1, 0); check("rst_u2", e2, 0);
      @(negedge clock);
    end
    k0 = a; k1 = b; k2 = c;
    n = 0;
    for (int i = 0; i < 3; i++) begin db[i] = rel(i); pc[i] = 0; last[i] = -1; end
    reset = 1'b1;
  endtask

  initial begin
    tv[0] = '{0, 0}; tv[1] = '{0, 0}; tv[2] = '{0, 1}; tv[3] = '{0, 0};
    tv[4] = '{1, 0}; tv[5] = '{1, 0}; tv[6] = '{0, 0}; tv[7] = '{0, 0};
    tv[8] = '{0, 1}; tv[9] = '{0, 0}; tv[10] = '{0, 0}; tv[11] = '{0, 0};
    do_reset(1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    do_reset(1, 1, 0);
    for (int i = 0; i < 12; i++) begin
      step(tv[i].k, 1, 0);
      check($sformatf("tbl_%0d", i), e0, tv[i].e);
    end
    do_reset(1, 1, 0);
    for (int len = 1; len <= 3; len++) begin
      for (int i = 0; i < len; i++) step(1, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 0);
    end
    check("glitch_pulses", pc[1], 0);
    begin
      int f;
      f = n + 1;
      for (int i = 0; i < 6; i++) step(1, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 1, 0);
      check("db4_pulses", pc[1], 1);
      check("db4_edge", last[1], f + 5);
    end
    do_reset(1, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1);
    check("ah_press", pc[2], 1);
    check("ah_edge", last[2], 4);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    check("ah_release", pc[2], 1);
    check("hold_once", pc[0], 1);
    do_reset(0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    check("held_u0", last[0], 3);
    check("held_u1", last[1], 6);
    check("held_u2", last[2], 4);
    do_reset(1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check("pre_async", e0, 1);
    #2 reset = 1'b0;
    #1 check("async_clear", e0, 0);
    do_reset(1, 1, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1'($urandom), 1'($urandom), 1'($urandom));
      step($urandom_range(0, 5) == 0 ? !k0 : k0,
           $urandom_range(0, 7) == 0 ? !k1 : k1,
           $urandom_range(0, 5) == 0 ? !k2 : k2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
